// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router output buffers.
package router_pkg;
    localparam int WIDTH_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 2;

    // Stored FIFO entry: header flag in the MSB, data byte below it.
    typedef logic [WIDTH_DEF:0] fifo_word_t;
endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointer pair with wrap bit; qualifies requests against full/empty.
module router_fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    output logic              do_write,
    output logic              do_read,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              full,
    output logic              empty
);
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    // Qualification uses pre-edge flags, so a full FIFO drops a concurrent write.
    assign do_write = write_enb && !full;
    assign do_read  = read_enb && !empty;
    assign wr_addr  = wr_ptr[ADDR_W-1:0];
    assign rd_addr  = rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router with packet-boundary tracking.
// Build option ROUTER_FIFO_HIZ_EN: idle data_out is high-impedance instead of 0.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);
`ifdef ROUTER_FIFO_HIZ_EN
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] IDLE = '0;
`endif

    logic [WIDTH:0]        mem [DEPTH];
    logic                  lfd_d;
    logic [6:0]            pkt_cnt;
    logic                  do_write;
    logic                  do_read;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [WIDTH:0]        rd_word;
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len;

    router_fifo_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .do_write   (do_write),
        .do_read    (do_read),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .full       (full),
        .empty      (empty)
    );

    assign rd_word = mem[rd_addr];
    assign hdr_len = rd_word[HDR_LEN_MSB:HDR_LEN_LSB];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            lfd_d    <= 1'b0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            lfd_d    <= 1'b0;
            pkt_cnt  <= '0;
            data_out <= IDLE;
        end else begin
            // Header reaches data_in one cycle after lfd_state.
            lfd_d <= lfd_state;
            if (do_write) mem[wr_addr] <= {lfd_d, data_in};
            if (do_read) begin
                data_out <= rd_word[WIDTH-1:0];
                // Header: payload length plus the trailing parity byte.
                if (rd_word[WIDTH])
                    pkt_cnt <= 7'({1'b0, hdr_len}) + 7'd1;
                else if (pkt_cnt != 7'd0)
                    pkt_cnt <= pkt_cnt - 7'd1;
            end else if (pkt_cnt == 7'd0) begin
                data_out <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, packet flow, overflow, wrap, concurrency, soft reset.
module tb_router_fifo;
    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;
    logic seen_full;

`ifdef ROUTER_FIFO_HIZ_EN
    localparam logic [7:0] IDLE = 8'hzz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        write_enb = 1'b1;
        data_in   = b;
        tick();
        write_enb = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        check(tag, data_out, exp);
    endtask

    task automatic lfd_pulse();
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        tick(); tick();
        check("rst_empty", {7'd0, empty}, 8'd1);
        check("rst_full", {7'd0, full}, 8'd0);
        check("rst_dout", data_out, 8'h00);
        resetn = 1'b1;

        // Read while empty must be ignored.
        rd_chk("empty_read_dout", IDLE);
        check("empty_read_empty", {7'd0, empty}, 8'd1);
        wr(8'h5A);
        check("one_wr_empty", {7'd0, empty}, 8'd0);
        rd_chk("one_rd", 8'h5A);
        check("one_rd_empty", {7'd0, empty}, 8'd1);

        // Packet flow: header 0D -> length 3, plus parity.
        lfd_pulse();
        wr(8'h0D); wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'h0C);
        rd_chk("pkt_hdr", 8'h0D);
        check("pkt_cnt_hdr", {1'b0, dut.pkt_cnt}, 8'd4);
        rd_chk("pkt_p1", 8'hA1);
        rd_chk("pkt_p2", 8'hA2);
        rd_chk("pkt_p3", 8'hA3);
        rd_chk("pkt_par", 8'h0C);
        check("pkt_cnt_end", {1'b0, dut.pkt_cnt}, 8'd0);
        tick();
        check("pkt_idle", data_out, IDLE);
        check("pkt_empty", {7'd0, empty}, 8'd1);

        // Fill and overflow.
        for (int i = 1; i <= 17; i++) begin
            wr((i == 17) ? 8'hFF : 8'(i));
            if (i == 15) check("fill15_full", {7'd0, full}, 8'd0);
            if (i == 16) check("fill16_full", {7'd0, full}, 8'd1);
        end
        check("fill17_full", {7'd0, full}, 8'd1);
        for (int i = 1; i <= 16; i++) rd_chk($sformatf("fill_rd%0d", i), 8'(i));
        check("fill_empty", {7'd0, empty}, 8'd1);

        // Wrap-around.
        seen_full = 1'b0;
        for (int i = 0; i < 12; i++) begin wr(8'h40 + 8'(i)); seen_full |= full; end
        for (int i = 0; i < 12; i++) rd_chk($sformatf("wrap_a%0d", i), 8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) begin wr(8'h60 + 8'(i)); seen_full |= full; end
        for (int i = 0; i < 10; i++) rd_chk($sformatf("wrap_b%0d", i), 8'h60 + 8'(i));
        check("wrap_empty", {7'd0, empty}, 8'd1);
        check("wrap_never_full", {7'd0, seen_full}, 8'd0);

        // Concurrent read and write while full.
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
        check("conc_full", {7'd0, full}, 8'd1);
        read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
        tick();
        read_enb = 1'b0; write_enb = 1'b0;
        check("conc_dout", data_out, 8'h80);
        check("conc_full_after", {7'd0, full}, 8'd0);
        for (int i = 1; i < 16; i++) rd_chk($sformatf("conc_rd%0d", i), 8'h80 + 8'(i));
        check("conc_empty", {7'd0, empty}, 8'd1);

        // Soft reset mid-packet: header 10 -> length 4.
        lfd_pulse();
        wr(8'h10); wr(8'hC1); wr(8'hC2); wr(8'hC3); wr(8'hC4); wr(8'h55);
        rd_chk("sr_hdr", 8'h10);
        rd_chk("sr_p1", 8'hC1);
        check("sr_cnt_before", {1'b0, dut.pkt_cnt}, 8'd4);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("sr_empty", {7'd0, empty}, 8'd1);
        check("sr_full", {7'd0, full}, 8'd0);
        check("sr_cnt", {1'b0, dut.pkt_cnt}, 8'd0);
        check("sr_dout", data_out, IDLE);

        // Next packet after soft reset: header 05 -> length 1.
        lfd_pulse();
        wr(8'h05); wr(8'hB1); wr(8'hC3);
        rd_chk("np_hdr", 8'h05);
        check("np_cnt_hdr", {1'b0, dut.pkt_cnt}, 8'd2);
        rd_chk("np_p1", 8'hB1);
        rd_chk("np_par", 8'hC3);
        tick();
        check("np_idle", data_out, IDLE);
        check("np_empty", {7'd0, empty}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
